// File: rtl/guvm_mem_arbiter_if.sv
// guvm_mem_arbiter_if
// req/gnt/rvalid bus used by the fetch port, the data port and the memory port of
// guvm_mem_arbiter.
//   master: drives req, we, be, addr, wdata; receives gnt, rvalid, rdata
//   slave : receives req, we, be, addr, wdata; drives gnt, rvalid, rdata
interface guvm_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/guvm_mem_arbiter.sv
// guvm_mem_arbiter
// Shares one single-port memory between an instruction-fetch port and a data port.
// Data has priority unless a fetch has been losing for STARVE_LIMIT cycles. An
// in-order ID FIFO remembers which port issued each granted transaction so memory
// responses can be routed back.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   instr_if       fetch port (slave); we/be/wdata are ignored
//   data_if        data port (slave)
//   mem_if         memory port (master)
//   outstanding_o  registered ID FIFO occupancy
//   err_o          sticky protocol error
module guvm_mem_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    guvm_mem_arbiter_if.slave                      instr_if,
    guvm_mem_arbiter_if.slave                      data_if,
    guvm_mem_arbiter_if.master                     mem_if,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BeW  = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StHoldI, StHoldD} state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    // One bit per outstanding transaction, head at bit 0: 1 = data, 0 = instr.
    logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;
    logic [StvW-1:0]            starve_q, starve_d;
    logic                       err_q, err_d;

    logic            full, starved;
    logic            drive_i, drive_d;
    logic            gnt_i, gnt_d;
    logic            push, pop;
    logic [CntW-1:0] wr_idx;
    logic            rvalid_i, rvalid_d;
    logic            mreq, mwe;
    logic [BeW-1:0]  mbe;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] mwdata;

    logic unused_instr_fields;
    assign unused_instr_fields = ^{instr_if.we, instr_if.be, instr_if.wdata};

    // Fullness uses the registered occupancy, so a pop cannot free a slot for a
    // grant in the same cycle.
    assign full    = (cnt_q == CntW'(MAX_OUTSTANDING));
    assign starved = (starve_q == StvW'(STARVE_LIMIT));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        drive_i = 1'b0;
        drive_d = 1'b0;
        case (state_q)
            StIdle: begin
                drive_i = !full && instr_if.req && (!data_if.req || starved);
                drive_d = !full && data_if.req && !drive_i;
                if (!mem_if.gnt) begin
                    if (drive_i) begin
                        state_d = StHoldI;
                    end else if (drive_d) begin
                        state_d = StHoldD;
                    end
                end
            end
            StHoldI: begin
                if (!instr_if.req) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    drive_i = 1'b1;
                    if (mem_if.gnt) state_d = StIdle;
                end
            end
            StHoldD: begin
                if (!data_if.req) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    drive_d = 1'b1;
                    if (mem_if.gnt) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        gnt_i = drive_i && mem_if.gnt;
        gnt_d = drive_d && mem_if.gnt;
        push  = gnt_i || gnt_d;

        // Memory side: fetches are always full-word reads.
        mreq   = drive_i || drive_d;
        mwe    = 1'b0;
        mbe    = '0;
        maddr  = '0;
        mwdata = '0;
        if (drive_i) begin
            mbe   = '1;
            maddr = instr_if.addr;
        end else if (drive_d) begin
            mwe    = data_if.we;
            mbe    = data_if.be;
            maddr  = data_if.addr;
            mwdata = data_if.wdata;
        end

        // Responses: a response with nothing outstanding is dropped and flagged.
        pop      = mem_if.rvalid && (cnt_q != '0);
        rvalid_i = pop && !ids_q[0];
        rvalid_d = pop && ids_q[0];
        if (mem_if.rvalid && (cnt_q == '0)) err_d = 1'b1;

        // ID FIFO as a shift register; push lands behind the surviving entries.
        ids_d  = pop ? (ids_q >> 1) : ids_q;
        wr_idx = pop ? (cnt_q - CntW'(1)) : cnt_q;
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (push && (CntW'(i) == wr_idx)) ids_d[i] = gnt_d;
        end

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (instr_if.req && !gnt_i) begin
            starve_d = starved ? starve_q : starve_q + StvW'(1);
        end else begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ids_q    <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ids_q    <= ids_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign instr_if.gnt    = gnt_i && !rst_i;
    assign instr_if.rvalid = rvalid_i && !rst_i;
    assign instr_if.rdata  = rst_i ? '0 : mem_if.rdata;
    assign data_if.gnt     = gnt_d && !rst_i;
    assign data_if.rvalid  = rvalid_d && !rst_i;
    assign data_if.rdata   = rst_i ? '0 : mem_if.rdata;
    assign mem_if.req      = mreq && !rst_i;
    assign mem_if.we       = mwe && !rst_i;
    assign mem_if.be       = rst_i ? '0 : mbe;
    assign mem_if.addr     = rst_i ? '0 : maddr;
    assign mem_if.wdata    = rst_i ? '0 : mwdata;
    assign outstanding_o   = cnt_q;
    assign err_o           = err_q;
endmodule

// File: tb/tb_guvm_mem_arbiter.sv
// Directed testbench for guvm_mem_arbiter (MAX_OUTSTANDING=2, STARVE_LIMIT=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_guvm_mem_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] outstanding;
    logic       err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    guvm_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) instr_bus ();
    guvm_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
    guvm_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    guvm_mem_arbiter #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .MAX_OUTSTANDING (2),
        .STARVE_LIMIT    (4)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_if      (instr_bus),
        .data_if       (data_bus),
        .mem_if        (mem_bus),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic set_idle();
        instr_bus.req   = 1'b0;
        instr_bus.we    = 1'b0;
        instr_bus.be    = 4'h0;
        instr_bus.addr  = 32'h0;
        instr_bus.wdata = 32'h0;
        data_bus.req    = 1'b0;
        data_bus.we     = 1'b0;
        data_bus.be     = 4'h0;
        data_bus.addr   = 32'h0;
        data_bus.wdata  = 32'h0;
        mem_bus.gnt     = 1'b0;
        mem_bus.rvalid  = 1'b0;
        mem_bus.rdata   = 32'h0;
    endtask

    logic        exp_i;
    logic        prev_i;
    logic [31:0] exp_addr;

    initial begin
        set_idle();
        // Reset: outputs held low even with a request and a memory grant.
        tick();
        instr_bus.req  = 1'b1;
        instr_bus.addr = 32'h40;
        mem_bus.gnt    = 1'b1;
        #1;
        check("rst_mem_req", mem_bus.req, 1'b0);
        check("rst_igrant", instr_bus.gnt, 1'b0);
        check("rst_outstanding", outstanding, 2'd0);
        check("rst_err", err, 1'b0);
        tick();
        set_idle();
        rst_i = 1'b0;

        // T1: lone data read, response two cycles after the grant.
        tick();
        data_bus.req  = 1'b1;
        data_bus.addr = 32'h100;
        data_bus.be   = 4'hf;
        mem_bus.gnt   = 1'b1;
        #1;
        check("t1_dgnt", data_bus.gnt, 1'b1);
        check("t1_mem_req", mem_bus.req, 1'b1);
        check("t1_mem_addr", mem_bus.addr, 32'h100);
        check("t1_mem_we", mem_bus.we, 1'b0);
        check("t1_out0", outstanding, 2'd0);
        tick();
        set_idle();
        #1;
        check("t1_out1", outstanding, 2'd1);
        tick();
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata  = 32'hDEADBEEF;
        #1;
        check("t1_drvalid", data_bus.rvalid, 1'b1);
        check("t1_irvalid", instr_bus.rvalid, 1'b0);
        check("t1_drdata", data_bus.rdata, 32'hDEADBEEF);
        check("t1_out2", outstanding, 2'd1);
        tick();
        set_idle();
        #1;
        check("t1_out3", outstanding, 2'd0);

        // T2: both request every cycle; expect D D D D I repeating.
        prev_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            instr_bus.req  = 1'b1;
            instr_bus.addr = 32'h4000;
            data_bus.req   = 1'b1;
            data_bus.addr  = 32'h8000;
            data_bus.be    = 4'hf;
            mem_bus.gnt    = 1'b1;
            mem_bus.rvalid = (k > 0);
            mem_bus.rdata  = 32'h1000 + k;
            #1;
            exp_i    = ((k % 5) == 4);
            exp_addr = exp_i ? 32'h4000 : 32'h8000;
            check("t2_igrant", instr_bus.gnt, exp_i);
            check("t2_dgrant", data_bus.gnt, !exp_i);
            check("t2_mem_addr", mem_bus.addr, exp_addr);
            check("t2_outstanding", outstanding, (k == 0) ? 2'd0 : 2'd1);
            if (k > 0) begin
                check("t2_irvalid", instr_bus.rvalid, prev_i);
                check("t2_drvalid", data_bus.rvalid, !prev_i);
                check("t2_rdata", instr_bus.rdata, 32'h1000 + k);
            end
            prev_i = exp_i;
        end
        tick();
        set_idle();
        mem_bus.rvalid = 1'b1;
        #1;
        check("t2_drain_irvalid", instr_bus.rvalid, 1'b1);
        check("t2_drain_drvalid", data_bus.rvalid, 1'b0);
        tick();
        set_idle();
        #1;
        check("t2_drain_out", outstanding, 2'd0);

        // T3: data write held off for 3 cycles while instr waits.
        for (int k = 0; k < 4; k++) begin
            tick();
            instr_bus.req  = 1'b1;
            instr_bus.addr = 32'h4000;
            data_bus.req   = 1'b1;
            data_bus.we    = 1'b1;
            data_bus.addr  = 32'h20;
            data_bus.be    = 4'b0011;
            data_bus.wdata = 32'h1234;
            mem_bus.gnt    = (k == 3);
            #1;
            check("t3_mem_req", mem_bus.req, 1'b1);
            check("t3_mem_we", mem_bus.we, 1'b1);
            check("t3_mem_addr", mem_bus.addr, 32'h20);
            check("t3_mem_be", mem_bus.be, 4'b0011);
            check("t3_mem_wdata", mem_bus.wdata, 32'h1234);
            check("t3_igrant", instr_bus.gnt, 1'b0);
            check("t3_dgrant", data_bus.gnt, (k == 3));
        end
        tick();
        set_idle();
        instr_bus.req  = 1'b1;
        instr_bus.addr = 32'h4004;
        mem_bus.gnt    = 1'b1;
        #1;
        check("t3_igrant_after", instr_bus.gnt, 1'b1);
        check("t3_fetch_we", mem_bus.we, 1'b0);
        check("t3_fetch_be", mem_bus.be, 4'hf);
        check("t3_fetch_wdata", mem_bus.wdata, 32'h0);
        check("t3_out_a", outstanding, 2'd1);
        tick();
        set_idle();
        mem_bus.rvalid = 1'b1;
        #1;
        check("t3_resp0_d", data_bus.rvalid, 1'b1);
        check("t3_resp0_i", instr_bus.rvalid, 1'b0);
        check("t3_out_b", outstanding, 2'd2);
        tick();
        mem_bus.rvalid = 1'b1;
        #1;
        check("t3_resp1_i", instr_bus.rvalid, 1'b1);
        check("t3_resp1_d", data_bus.rvalid, 1'b0);
        tick();
        set_idle();
        #1;
        check("t3_out_c", outstanding, 2'd0);

        // T4: FIFO full blocks grants, including in the pop cycle.
        for (int k = 0; k < 2; k++) begin
            tick();
            instr_bus.req  = 1'b1;
            instr_bus.addr = 32'h200 + 4 * k;
            mem_bus.gnt    = 1'b1;
            #1;
            check("t4_igrant", instr_bus.gnt, 1'b1);
        end
        tick();
        #1;
        check("t4_full_out", outstanding, 2'd2);
        check("t4_full_igrant", instr_bus.gnt, 1'b0);
        check("t4_full_mem_req", mem_bus.req, 1'b0);
        tick();
        mem_bus.rvalid = 1'b1;
        #1;
        check("t4_pop_irvalid", instr_bus.rvalid, 1'b1);
        check("t4_pop_igrant", instr_bus.gnt, 1'b0);
        check("t4_pop_mem_req", mem_bus.req, 1'b0);
        tick();
        mem_bus.rvalid = 1'b0;
        #1;
        check("t4_next_igrant", instr_bus.gnt, 1'b1);
        check("t4_next_out", outstanding, 2'd1);
        tick();
        set_idle();
        mem_bus.rvalid = 1'b1;
        #1;
        check("t4_drain_out2", outstanding, 2'd2);
        tick();
        mem_bus.rvalid = 1'b1;
        #1;
        check("t4_drain_irvalid", instr_bus.rvalid, 1'b1);
        tick();
        set_idle();
        #1;
        check("t4_drain_out0", outstanding, 2'd0);
        check("t4_err", err, 1'b0);

        // Held data request dropped before grant.
        tick();
        data_bus.req  = 1'b1;
        data_bus.addr = 32'h300;
        #1;
        check("drop_hold_req", mem_bus.req, 1'b1);
        tick();
        set_idle();
        #1;
        check("drop_mem_req", mem_bus.req, 1'b0);
        check("drop_dgrant", data_bus.gnt, 1'b0);
        tick();
        #1;
        check("drop_err", err, 1'b1);

        // Reset in HOLD_D with one transaction outstanding.
        tick();
        set_idle();
        instr_bus.req  = 1'b1;
        instr_bus.addr = 32'h500;
        mem_bus.gnt    = 1'b1;
        #1;
        check("rmid_igrant", instr_bus.gnt, 1'b1);
        tick();
        set_idle();
        data_bus.req  = 1'b1;
        data_bus.addr = 32'h600;
        #1;
        check("rmid_hold_req", mem_bus.req, 1'b1);
        tick();
        #1;
        check("rmid_hold_out", outstanding, 2'd1);
        check("rmid_hold_dgrant", data_bus.gnt, 1'b0);
        tick();
        rst_i         = 1'b1;
        mem_bus.gnt   = 1'b1;
        mem_bus.rdata = 32'h55;
        #1;
        check("rmid_mem_req", mem_bus.req, 1'b0);
        check("rmid_mem_addr", mem_bus.addr, 32'h0);
        check("rmid_dgrant", data_bus.gnt, 1'b0);
        check("rmid_drdata", data_bus.rdata, 32'h0);
        check("rmid_out", outstanding, 2'd0);
        check("rmid_err", err, 1'b0);
        tick();
        set_idle();
        rst_i = 1'b0;
        #1;
        check("rmid_rel_out", outstanding, 2'd0);

        // Stale response after reset: dropped and flagged.
        tick();
        mem_bus.rvalid = 1'b1;
        #1;
        check("stale_irvalid", instr_bus.rvalid, 1'b0);
        check("stale_drvalid", data_bus.rvalid, 1'b0);
        tick();
        set_idle();
        instr_bus.req  = 1'b1;
        instr_bus.addr = 32'h700;
        mem_bus.gnt    = 1'b1;
        #1;
        check("stale_err", err, 1'b1);
        check("rmid_idle_igrant", instr_bus.gnt, 1'b1);
        tick();
        set_idle();
        mem_bus.rvalid = 1'b1;
        #1;
        check("post_irvalid", instr_bus.rvalid, 1'b1);
        tick();
        set_idle();
        tick();
        #1;
        check("err_sticky", err, 1'b1);
        tick();
        rst_i = 1'b1;
        #1;
        check("err_cleared", err, 1'b0);
        tick();
        rst_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
